// File: rtl/try1_pkg.sv
// Purpose: shared types and default constants for the try1 debounce block.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package try1_pkg;

  // Debounce FSM states: two stable levels and two pending transitions.
  typedef enum logic [1:0] {
    LOW_STABLE  = 2'd0,
    RISE_PEND   = 2'd1,
    HIGH_STABLE = 2'd2,
    FALL_PEND   = 2'd3
  } state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEBOUNCE    = 8;

endpackage

// File: rtl/try1_sync.sv
// Purpose: N-stage single-bit synchronizer, plain flop chain, resets to 0.
// Latency: STAGES rising edges from input capture to q.
// Backpressure: none; samples every cycle.
module try1_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift the raw level through the chain; nothing sits between stages.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ff <= '0;
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/try1_debounce.sv
// Purpose: synchronize and debounce a raw input level into a clean registered o.
// Latency: o follows a stable change of i after SYNC_STAGES+DEBOUNCE rising edges.
// Backpressure: none; excursions of s shorter than DEBOUNCE cycles are dropped.
module try1_debounce
  import try1_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEBOUNCE    = DEF_DEBOUNCE
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i,
  output logic o
);

  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  // The counter holds how many consecutive cycles s has already shown the new
  // level; the DEBOUNCE-th such observation commits the change, so the count
  // itself never rises above DEBOUNCE-1.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  logic   s;
  state_t state;
  logic [CNT_W-1:0] cnt;

  try1_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (i),
    .q     (s)
  );

  // Debounce FSM: commit a level only after it holds for DEBOUNCE cycles of s.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOW_STABLE;
      cnt   <= '0;
      o     <= 1'b0;
    end else begin
      case (state)
        LOW_STABLE: begin
          if (s) begin
            // With a one-cycle window the first observation already commits.
            if (DEBOUNCE == 1) begin
              state <= HIGH_STABLE;
              o     <= 1'b1;
              cnt   <= '0;
            end else begin
              state <= RISE_PEND;
              cnt   <= ONE;
            end
          end else begin
            cnt <= '0;
          end
        end
        RISE_PEND: begin
          if (!s) begin
            state <= LOW_STABLE;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= HIGH_STABLE;
            o     <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        HIGH_STABLE: begin
          if (!s) begin
            if (DEBOUNCE == 1) begin
              state <= LOW_STABLE;
              o     <= 1'b0;
              cnt   <= '0;
            end else begin
              state <= FALL_PEND;
              cnt   <= ONE;
            end
          end else begin
            cnt <= '0;
          end
        end
        FALL_PEND: begin
          if (s) begin
            state <= HIGH_STABLE;
            cnt   <= '0;
          end else if (cnt == LAST) begin
            state <= LOW_STABLE;
            o     <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        default: begin
          state <= LOW_STABLE;
          cnt   <= '0;
          o     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_try1_debounce.sv
// Purpose: self-checking bench for try1_debounce (default and DEBOUNCE=1/SYNC_STAGES=3).
// Latency: checks exact edge counts for rise, fall, glitch and reset-release.
// Backpressure: n/a; random level runs are compared with a reference model.
module tb_try1_debounce;

  localparam int SA = 2;
  localparam int DA = 8;
  localparam int SB = 3;
  localparam int DB = 1;

  logic clk = 1'b0;
  logic rst_n;
  logic i;
  logic o_a;
  logic o_b;

  int checks = 0;
  int errors = 0;

  // Reference model: i as seen at each edge, delayed by the synchronizer
  // depth, and a count of consecutive cycles it disagrees with o.
  bit qa[$];
  bit qb[$];
  int ca;
  int cb;
  bit ma;
  bit mb;

  always #5 clk = ~clk;

  try1_debounce dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .i     (i),
    .o     (o_a)
  );

  try1_debounce #(
    .SYNC_STAGES (SB),
    .DEBOUNCE    (DB)
  ) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .i     (i),
    .o     (o_b)
  );

  task automatic model_reset();
    qa.delete();
    qb.delete();
    for (int k = 0; k < SA; k++) qa.push_back(1'b0);
    for (int k = 0; k < SB; k++) qb.push_back(1'b0);
    ca = 0;
    cb = 0;
    ma = 1'b0;
    mb = 1'b0;
  endtask

  task automatic model_step();
    bit sa;
    bit sb;
    sa = qa.pop_front();
    qa.push_back(i);
    sb = qb.pop_front();
    qb.push_back(i);
    if (sa != ma) begin
      ca++;
      if (ca == DA) begin
        ma = sa;
        ca = 0;
      end
    end else begin
      ca = 0;
    end
    if (sb != mb) begin
      cb++;
      if (cb == DB) begin
        mb = sb;
        cb = 0;
      end
    end else begin
      cb = 0;
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: model updates at the edge, both outputs compared at the negedge.
  task automatic tick();
    @(posedge clk);
    if (rst_n) model_step();
    @(negedge clk);
    check("model_a", o_a, ma);
    check("model_b", o_b, mb);
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  initial begin
    rst_n = 1'b0;
    i     = 1'b0;
    model_reset();

    // Reset hold with i low, then 50 quiet cycles.
    for (int n = 0; n < 10; n++) begin
      tick();
      check("reset_hold_a", o_a, 1'b0);
      check("reset_hold_b", o_b, 1'b0);
    end
    rst_n = 1'b1;
    for (int n = 0; n < 50; n++) begin
      tick();
      check("post_reset_a", o_a, 1'b0);
    end

    // Rise: i changes between edges; o_a after 10 edges, o_b after 4.
    i = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      check("rise_lat_a", o_a, logic'(n >= 10));
      check("rise_lat_b", o_b, logic'(n >= 4));
    end
    ticks(50);
    check("rise_hold_a", o_a, 1'b1);

    // Fall.
    i = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      tick();
      check("fall_lat_a", o_a, logic'(n < 10));
      check("fall_lat_b", o_b, logic'(n < 4));
    end
    ticks(20);

    // Glitch of DEBOUNCE-1 cycles is rejected by dut_a (dut_b passes it).
    i = 1'b1;
    ticks(7);
    i = 1'b0;
    for (int n = 0; n < 20; n++) begin
      tick();
      check("glitch7_a", o_a, 1'b0);
    end

    // A pulse of exactly DEBOUNCE cycles is passed, ten edges after the rise.
    i = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      if (n == 9) i = 1'b0;
      tick();
      check("pulse8_a", o_a, logic'(n >= 10));
    end
    ticks(20);
    check("pulse8_fall_a", o_a, 1'b0);

    // Async reset while a rise is pending; dut_b has already committed high.
    i = 1'b1;
    ticks(5);
    check("pre_reset_b", o_b, 1'b1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_reset_a", o_a, 1'b0);
    check("async_reset_b", o_b, 1'b0);
    ticks(3);
    rst_n = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      check("release_high_a", o_a, logic'(n >= 10));
      check("release_high_b", o_b, logic'(n >= 4));
    end

    // Randomized level runs, including single-cycle pulses.
    for (int r = 0; r < 60; r++) begin
      i = 1'($urandom_range(0, 1));
      ticks(int'($urandom_range(1, 12)));
    end
    i = 1'b0;
    ticks(20);
    check("final_low_a", o_a, 1'b0);
    check("final_low_b", o_b, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
